// File: rtl/regfile_sb.sv
// General-purpose register file with two combinational read ports, one write port,
// optional hardwired x0, optional write-to-read bypass and a per-register busy scoreboard.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    input  logic             rs1_used,
    input  logic             rs2_used,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    input  logic             we,
    input  logic [AW-1:0]    rd_addr,
    input  logic [XLEN-1:0]  rd_data,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    output logic             stall,
    output logic [NREGS-1:0] busy_vec
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic             w_wr_zero;
    logic             w_byp1;
    logic             w_byp2;
    logic             w_haz1;
    logic             w_haz2;

    assign w_wr_zero = (ZERO_REG != 0) && (rd_addr == '0);

    // Forwarding is only taken when the write port targets the same register this cycle.
    assign w_byp1 = (BYPASS != 0) && we && (rd_addr == rs1_addr);
    assign w_byp2 = (BYPASS != 0) && we && (rd_addr == rs2_addr);

    function automatic logic [XLEN-1:0] read_sel(input logic [AW-1:0]   addr,
                                                 input logic            byp,
                                                 input logic [XLEN-1:0] wdata,
                                                 input logic [XLEN-1:0] stored);
        if ((ZERO_REG != 0) && (addr == '0))
            return '0;
        else if (byp)
            return wdata;
        else
            return stored;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else if (we && !w_wr_zero) begin
            r_regs[rd_addr] <= rd_data;
        end
    end

    // A new producer issuing to a register wins over a writeback clearing it.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 0; i < NREGS; i++) begin
            if (issue_valid && (issue_rd == AW'(i)))
                w_busy_nxt[i] = 1'b1;
            else if (we && (rd_addr == AW'(i)))
                w_busy_nxt[i] = 1'b0;
        end
        if (ZERO_REG != 0)
            w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    assign rs1_data = read_sel(rs1_addr, w_byp1, rd_data, r_regs[rs1_addr]);
    assign rs2_data = read_sel(rs2_addr, w_byp2, rd_data, r_regs[rs2_addr]);

    assign w_haz1   = rs1_used && r_busy[rs1_addr] && !w_byp1;
    assign w_haz2   = rs2_used && r_busy[rs2_addr] && !w_byp2;
    assign stall    = w_haz1 || w_haz2;
    assign busy_vec = r_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a default (bypassing) instance and a small non-bypassing one.
module tb_regfile_sb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: XLEN=32, NREGS=32, ZERO_REG=1, BYPASS=1
    logic [4:0]  a_rs1_addr = '0, a_rs2_addr = '0, a_rd_addr = '0, a_issue_rd = '0;
    logic        a_rs1_used = 0, a_rs2_used = 0, a_we = 0, a_issue_valid = 0;
    logic [31:0] a_rd_data = '0;
    logic [31:0] a_rs1_data, a_rs2_data;
    logic        a_stall;
    logic [31:0] a_busy_vec;

    // Instance B: XLEN=16, NREGS=8, ZERO_REG=1, BYPASS=0
    logic [2:0]  b_rs1_addr = '0, b_rs2_addr = '0, b_rd_addr = '0, b_issue_rd = '0;
    logic        b_rs1_used = 0, b_rs2_used = 0, b_we = 0, b_issue_valid = 0;
    logic [15:0] b_rd_data = '0;
    logic [15:0] b_rs1_data, b_rs2_data;
    logic        b_stall;
    logic [7:0]  b_busy_vec;

    regfile_sb u_a (
        .clk(clk), .rst(rst),
        .rs1_addr(a_rs1_addr), .rs2_addr(a_rs2_addr),
        .rs1_used(a_rs1_used), .rs2_used(a_rs2_used),
        .rs1_data(a_rs1_data), .rs2_data(a_rs2_data),
        .we(a_we), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .issue_valid(a_issue_valid), .issue_rd(a_issue_rd),
        .stall(a_stall), .busy_vec(a_busy_vec)
    );

    regfile_sb #(.XLEN(16), .NREGS(8), .ZERO_REG(1), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst),
        .rs1_addr(b_rs1_addr), .rs2_addr(b_rs2_addr),
        .rs1_used(b_rs1_used), .rs2_used(b_rs2_used),
        .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
        .we(b_we), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .issue_valid(b_issue_valid), .issue_rd(b_issue_rd),
        .stall(b_stall), .busy_vec(b_busy_vec)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if (a_busy_vec !== 32'h0 || a_stall !== 1'b0 || a_rs1_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_initial busy=%h stall=%b rs1=%h, expected 0/0/0", a_busy_vec, a_stall, a_rs1_data);
        end
        tick();
        rst = 1'b0;
        a_we = 1; a_rd_addr = 5; a_rd_data = 32'hDEADBEEF;
        a_issue_valid = 1; a_issue_rd = 6;
        tick();
        a_we = 0; a_issue_valid = 0; a_rs1_addr = 5;
        #1;
        n_checks++;
        if (a_rs1_data !== 32'hDEADBEEF || a_busy_vec !== 32'h0000_0040) begin
            n_fail++;
            $display("FAIL reset_prewrite rs1=%h busy=%h, expected deadbeef/00000040", a_rs1_data, a_busy_vec);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (a_rs1_data !== 32'h0 || a_busy_vec !== 32'h0 || a_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async rs1=%h busy=%h stall=%b, expected 0/0/0", a_rs1_data, a_busy_vec, a_stall);
        end
        // operations presented across an edge while reset is held must be discarded
        a_we = 1; a_rd_addr = 5; a_rd_data = 32'h1111_2222;
        a_issue_valid = 1; a_issue_rd = 5;
        tick();
        rst = 1'b0;
        a_we = 0; a_issue_valid = 0;
        #1;
        n_checks++;
        if (a_rs1_data !== 32'h0 || a_busy_vec !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_discard rs1=%h busy=%h, expected 0/0", a_rs1_data, a_busy_vec);
        end
    endtask

    task automatic test_write_read();
        a_we = 1; a_rd_addr = 7; a_rd_data = 32'h12345678; a_rs1_addr = 7;
        #1;
        n_checks++;
        if (a_rs1_data !== 32'h12345678) begin
            n_fail++;
            $display("FAIL wr_bypass rs1=%h, expected 12345678", a_rs1_data);
        end
        tick();
        a_we = 0;
        #1;
        n_checks++;
        if (a_rs1_data !== 32'h12345678) begin
            n_fail++;
            $display("FAIL wr_stored rs1=%h, expected 12345678", a_rs1_data);
        end
        a_we = 1; a_rd_addr = 0; a_rd_data = 32'hFFFFFFFF;
        a_issue_valid = 1; a_issue_rd = 0; a_rs1_addr = 0;
        #1;
        n_checks++;
        if (a_rs1_data !== 32'h0) begin
            n_fail++;
            $display("FAIL x0_bypass rs1=%h, expected 0", a_rs1_data);
        end
        tick();
        a_we = 0; a_issue_valid = 0;
        #1;
        n_checks++;
        if (a_rs1_data !== 32'h0 || a_busy_vec !== 32'h0) begin
            n_fail++;
            $display("FAIL x0_after rs1=%h busy=%h, expected 0/0", a_rs1_data, a_busy_vec);
        end
    endtask

    task automatic test_hazard();
        a_issue_valid = 1; a_issue_rd = 3;
        a_rs2_addr = 3; a_rs2_used = 1;
        #1;
        n_checks++;
        if (a_busy_vec !== 32'h0 || a_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL haz_before_edge busy=%h stall=%b, expected 0/0", a_busy_vec, a_stall);
        end
        tick();
        a_issue_valid = 0;
        #1;
        n_checks++;
        if (a_busy_vec !== 32'h0000_0008 || a_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL haz_busy busy=%h stall=%b, expected 00000008/1", a_busy_vec, a_stall);
        end
        a_we = 1; a_rd_addr = 3; a_rd_data = 32'hA5;
        #1;
        n_checks++;
        if (a_stall !== 1'b0 || a_rs2_data !== 32'hA5) begin
            n_fail++;
            $display("FAIL haz_wb_cycle stall=%b rs2=%h, expected 0/000000a5", a_stall, a_rs2_data);
        end
        tick();
        a_we = 0;
        #1;
        n_checks++;
        if (a_busy_vec !== 32'h0 || a_stall !== 1'b0 || a_rs2_data !== 32'hA5) begin
            n_fail++;
            $display("FAIL haz_cleared busy=%h stall=%b rs2=%h, expected 0/0/a5", a_busy_vec, a_stall, a_rs2_data);
        end
        a_issue_valid = 1; a_issue_rd = 3;
        tick();
        a_issue_valid = 0; a_rs2_used = 0;
        #1;
        n_checks++;
        if (a_stall !== 1'b0 || a_busy_vec !== 32'h0000_0008) begin
            n_fail++;
            $display("FAIL haz_unused stall=%b busy=%h, expected 0/00000008", a_stall, a_busy_vec);
        end
        a_rs1_addr = 3; a_rs1_used = 1;
        #1;
        n_checks++;
        if (a_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL haz_rs1 stall=%b, expected 1", a_stall);
        end
        a_we = 1; a_rd_addr = 3; a_rd_data = 32'hA6;
        tick();
        a_we = 0; a_rs1_used = 0;
    endtask

    task automatic test_collision();
        a_issue_valid = 1; a_issue_rd = 9;
        tick();
        a_we = 1; a_rd_addr = 9; a_rd_data = 32'h0000_0099;
        tick();
        a_we = 0; a_issue_valid = 0; a_rs1_addr = 9;
        #1;
        n_checks++;
        if (a_busy_vec !== 32'h0000_0200 || a_rs1_data !== 32'h0000_0099) begin
            n_fail++;
            $display("FAIL collision busy=%h rs1=%h, expected 00000200/00000099", a_busy_vec, a_rs1_data);
        end
        a_we = 1; a_rd_data = 32'h0000_009A;
        tick();
        a_we = 0;
        #1;
        n_checks++;
        if (a_busy_vec !== 32'h0) begin
            n_fail++;
            $display("FAIL collision_clear busy=%h, expected 0", a_busy_vec);
        end
    endtask

    task automatic test_no_bypass();
        b_issue_valid = 1; b_issue_rd = 2;
        tick();
        b_issue_valid = 0; b_rs1_addr = 2; b_rs1_used = 1;
        #1;
        n_checks++;
        if (b_stall !== 1'b1 || b_busy_vec !== 8'h04) begin
            n_fail++;
            $display("FAIL nb_busy stall=%b busy=%h, expected 1/04", b_stall, b_busy_vec);
        end
        b_we = 1; b_rd_addr = 2; b_rd_data = 16'h00BE;
        #1;
        n_checks++;
        if (b_stall !== 1'b1 || b_rs1_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL nb_write_cycle stall=%b rs1=%h, expected 1/0000", b_stall, b_rs1_data);
        end
        tick();
        b_we = 0;
        #1;
        n_checks++;
        if (b_stall !== 1'b0 || b_rs1_data !== 16'h00BE || b_busy_vec !== 8'h00) begin
            n_fail++;
            $display("FAIL nb_after stall=%b rs1=%h busy=%h, expected 0/00be/00", b_stall, b_rs1_data, b_busy_vec);
        end
        b_rs1_used = 0;
        for (int i = 1; i < 8; i++) begin
            b_we = 1; b_rd_addr = 3'(i); b_rd_data = 16'h1000 + 16'(i);
            tick();
        end
        b_we = 0;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] exp;
            exp = (i == 0) ? 16'h0000 : 16'h1000 + 16'(i);
            b_rs1_addr = 3'(i); b_rs2_addr = 3'(7 - i);
            #1;
            n_checks++;
            if (b_rs1_data !== exp) begin
                n_fail++;
                $display("FAIL nb_addr rs1[%0d]=%h, expected %h", i, b_rs1_data, exp);
            end
            exp = (i == 7) ? 16'h0000 : 16'h1000 + 16'(7 - i);
            n_checks++;
            if (b_rs2_data !== exp) begin
                n_fail++;
                $display("FAIL nb_addr rs2[%0d]=%h, expected %h", 7 - i, b_rs2_data, exp);
            end
        end
    endtask

    task automatic test_dual_read();
        a_we = 1; a_rd_addr = 4; a_rd_data = 32'h55;
        tick();
        a_we = 0; a_rs1_addr = 4; a_rs2_addr = 4;
        #1;
        n_checks++;
        if (a_rs1_data !== 32'h55 || a_rs2_data !== 32'h55) begin
            n_fail++;
            $display("FAIL dual_read rs1=%h rs2=%h, expected 55/55", a_rs1_data, a_rs2_data);
        end
        a_we = 1; a_rd_addr = 4; a_rd_data = 32'h66;
        #1;
        n_checks++;
        if (a_rs1_data !== 32'h66 || a_rs2_data !== 32'h66) begin
            n_fail++;
            $display("FAIL dual_bypass rs1=%h rs2=%h, expected 66/66", a_rs1_data, a_rs2_data);
        end
        tick();
        a_we = 0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_hazard();
        test_collision();
        test_no_bypass();
        test_dual_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
